// File: rtl/regfile_mp.sv
// Multi-port register file: N_WR writers, N_RD registered readers, sync reset.
// Define RF_BYPASS_EN to forward same-cycle write data to reads (new data).
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 1 << ADDR_W,
    parameter int N_RD    = 2,
    parameter int N_WR    = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_WR-1:0]          i_wr_en,
    input  logic [N_WR*ADDR_W-1:0]   i_wr_addr,
    input  logic [N_WR*DATA_W-1:0]   i_wr_data,
    input  logic [N_RD-1:0]          i_rd_en,
    input  logic [N_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [N_RD*DATA_W-1:0]   o_rd_data,
    output logic [N_RD-1:0]          o_rd_valid,
    output logic                     o_wr_conflict
);

    localparam int AW1 = ADDR_W + 1;

    logic [DATA_W-1:0]      r_mem [DEPTH];
    logic [N_RD*DATA_W-1:0] r_rd_data;
    logic [N_RD-1:0]        r_rd_valid;
    logic                   r_wr_conflict;

    logic [N_WR-1:0]        w_wr_ok;
    logic                   w_conflict;
    logic [N_RD*DATA_W-1:0] w_rd_next;

    // Out-of-range and hardwired-zero addresses are neither stored nor read.
    function automatic logic f_live(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < AW1'(DEPTH)) && (ZERO_R0 == 0 || a != '0);
    endfunction

    always_comb begin
        w_wr_ok = '0;
        for (int p = 0; p < N_WR; p++) begin
            w_wr_ok[p] = i_wr_en[p] && f_live(i_wr_addr[p*ADDR_W +: ADDR_W]);
        end
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int a = 0; a < N_WR; a++) begin
            for (int b = a + 1; b < N_WR; b++) begin
                if (w_wr_ok[a] && w_wr_ok[b] &&
                    i_wr_addr[a*ADDR_W +: ADDR_W] == i_wr_addr[b*ADDR_W +: ADDR_W]) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rd_next = '0;
        for (int q = 0; q < N_RD; q++) begin
            if (f_live(i_rd_addr[q*ADDR_W +: ADDR_W])) begin
                w_rd_next[q*DATA_W +: DATA_W] = r_mem[i_rd_addr[q*ADDR_W +: ADDR_W]];
            end
`ifdef RF_BYPASS_EN
            // Ascending scan so the highest writer supplies the forwarded data.
            for (int p = 0; p < N_WR; p++) begin
                if (w_wr_ok[p] &&
                    i_wr_addr[p*ADDR_W +: ADDR_W] == i_rd_addr[q*ADDR_W +: ADDR_W]) begin
                    w_rd_next[q*DATA_W +: DATA_W] = i_wr_data[p*DATA_W +: DATA_W];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data     <= '0;
            r_rd_valid    <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            for (int p = 0; p < N_WR; p++) begin
                if (w_wr_ok[p]) begin
                    r_mem[i_wr_addr[p*ADDR_W +: ADDR_W]] <= i_wr_data[p*DATA_W +: DATA_W];
                end
            end
            for (int q = 0; q < N_RD; q++) begin
                if (i_rd_en[q]) begin
                    r_rd_data[q*DATA_W +: DATA_W] <= w_rd_next[q*DATA_W +: DATA_W];
                end
            end
            r_rd_valid    <= i_rd_en;
            r_wr_conflict <= w_conflict;
        end
    end

    assign o_rd_data     = r_rd_data;
    assign o_rd_valid    = r_rd_valid;
    assign o_wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (2 writers, 2 readers, DEPTH=24).
// Expected reads come from a bench-side model and flow through a scoreboard queue.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DP = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic [1:0]    rd_en;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [1:0]    rd_valid;
    logic          wr_conflict;

    regfile_mp #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP),
        .N_RD(2), .N_WR(2), .ZERO_R0(1)
    ) dut (
        .clk(clk), .rst(rst),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .o_wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [DP];
    logic        exp_conf;
    int          n_chk = 0;
    int          n_pass = 0;

    function automatic logic live(input int a);
        return (a > 0) && (a < DP);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle, pushes expected reads from the model, then advances it.
    task automatic cycle(input logic [1:0] we, input int wa0, input int wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic [1:0] re, input int ra0, input int ra1);
        int          wa[2];
        int          ra[2];
        logic [31:0] wd[2];
        logic [31:0] v;
        wa[0] = wa0; wa[1] = wa1; ra[0] = ra0; ra[1] = ra1;
        wd[0] = wd0; wd[1] = wd1;
        wr_en   = we;
        wr_addr = {AW'(wa1), AW'(wa0)};
        wr_data = {wd1, wd0};
        rd_en   = re;
        rd_addr = {AW'(ra1), AW'(ra0)};
        for (int q = 0; q < 2; q++) begin
            if (re[q]) begin
                v = live(ra[q]) ? mdl[ra[q]] : 32'h0;
`ifdef RF_BYPASS_EN
                for (int p = 0; p < 2; p++) begin
                    if (we[p] && live(wa[p]) && wa[p] == ra[q]) v = wd[p];
                end
`endif
                sb.push_back('{q, v});
            end
        end
        exp_conf = we[0] && we[1] && live(wa0) && wa0 == wa1;
        for (int p = 0; p < 2; p++) begin
            if (we[p] && live(wa[p])) mdl[wa[p]] = wd[p];
        end
        tick();
        wr_en = '0;
        rd_en = '0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; wr_en = '0; rd_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        tick(); tick();
        n_chk++;
        if (rd_valid !== 2'b00 || rd_data !== '0 || wr_conflict !== 1'b0)
            $display("FAIL reset_state: valid=%b data=%h conf=%b want 00/0/0",
                     rd_valid, rd_data, wr_conflict);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < DP; i++) mdl[i] = '0;
        cycle(2'b01, 5, 0, 32'hDEADBEEF, 0, 2'b00, 0, 0);
        rst = 1'b1;
        wr_en = 2'b11; wr_addr = {AW'(6), AW'(5)}; wr_data = {32'h1, 32'h2};
        rd_en = 2'b11; rd_addr = {AW'(5), AW'(5)};
        tick();
        n_chk++;
        if (rd_valid !== 2'b00 || rd_data !== '0)
            $display("FAIL reset_override: valid=%b data=%h want 00/0", rd_valid, rd_data);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < DP; i++) mdl[i] = '0;
        cycle(2'b00, 0, 0, 0, 0, 2'b11, 5, 6);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (rd_data[e.port*DW +: DW] !== e.data || rd_valid[e.port] !== 1'b1)
                $display("FAIL reset_read p%0d: got %h v=%b want %h v=1",
                         e.port, rd_data[e.port*DW +: DW], rd_valid[e.port], e.data);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        exp_t e;
        cycle(2'b01, 3, 0, 32'h12345678, 0, 2'b00, 0, 0);
        cycle(2'b00, 0, 0, 0, 0, 2'b11, 3, 3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (rd_data[e.port*DW +: DW] !== e.data || rd_valid[e.port] !== 1'b1)
                $display("FAIL basic_rw p%0d: got %h v=%b want %h v=1",
                         e.port, rd_data[e.port*DW +: DW], rd_valid[e.port], e.data);
            else n_pass++;
        end
    endtask

    task automatic test_zero_reg();
        exp_t e;
        cycle(2'b11, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 0, 0);
        n_chk++;
        if (wr_conflict !== 1'b0)
            $display("FAIL zero_conflict: got %b want 0", wr_conflict);
        else n_pass++;
        cycle(2'b00, 0, 0, 0, 0, 2'b11, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (rd_data[e.port*DW +: DW] !== e.data)
                $display("FAIL zero_read p%0d: got %h want %h",
                         e.port, rd_data[e.port*DW +: DW], e.data);
            else n_pass++;
        end
    endtask

    task automatic test_collision();
        exp_t e;
        cycle(2'b11, 7, 7, 32'hA, 32'hB, 2'b00, 0, 0);
        n_chk++;
        if (wr_conflict !== exp_conf || exp_conf !== 1'b1)
            $display("FAIL collide_flag: got %b want 1", wr_conflict);
        else n_pass++;
        cycle(2'b00, 0, 0, 0, 0, 2'b01, 7, 0);
        n_chk++;
        if (wr_conflict !== 1'b0)
            $display("FAIL collide_clear: got %b want 0", wr_conflict);
        else n_pass++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (rd_data[e.port*DW +: DW] !== e.data)
                $display("FAIL collide_read p%0d: got %h want %h",
                         e.port, rd_data[e.port*DW +: DW], e.data);
            else n_pass++;
        end
    endtask

    task automatic test_rdw();
        exp_t e;
        cycle(2'b01, 9, 0, 32'h1, 0, 2'b00, 0, 0);
        cycle(2'b10, 0, 9, 0, 32'h2, 2'b11, 9, 9);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (rd_data[e.port*DW +: DW] !== e.data)
                $display("FAIL rdw_same p%0d: got %h want %h",
                         e.port, rd_data[e.port*DW +: DW], e.data);
            else n_pass++;
        end
        cycle(2'b00, 0, 0, 0, 0, 2'b01, 9, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (rd_data[e.port*DW +: DW] !== e.data)
                $display("FAIL rdw_next p%0d: got %h want %h",
                         e.port, rd_data[e.port*DW +: DW], e.data);
            else n_pass++;
        end
    endtask

    task automatic test_hold_range();
        exp_t        e;
        logic [31:0] held;
        cycle(2'b11, 4, 23, 32'h44, 32'h2323, 2'b00, 0, 0);
        cycle(2'b00, 0, 0, 0, 0, 2'b11, 4, 23);
        held = 32'h0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port == 0) held = e.data;
            n_chk++;
            if (rd_data[e.port*DW +: DW] !== e.data)
                $display("FAIL hold_first p%0d: got %h want %h",
                         e.port, rd_data[e.port*DW +: DW], e.data);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
            n_chk++;
            if (rd_data[DW-1:0] !== held || rd_valid !== 2'b00)
                $display("FAIL hold_idle%0d: got %h v=%b want %h v=00",
                         i, rd_data[DW-1:0], rd_valid, held);
            else n_pass++;
        end
        cycle(2'b11, 30, 30, 32'h5, 32'h6, 2'b00, 0, 0);
        n_chk++;
        if (wr_conflict !== 1'b0)
            $display("FAIL range_conflict: got %b want 0", wr_conflict);
        else n_pass++;
        cycle(2'b00, 0, 0, 0, 0, 2'b11, 30, 24);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (rd_data[e.port*DW +: DW] !== e.data)
                $display("FAIL range_read p%0d: got %h want %h",
                         e.port, rd_data[e.port*DW +: DW], e.data);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            cycle(2'($urandom_range(0, 3)),
                  $urandom_range(0, 25), $urandom_range(0, 25),
                  $urandom, $urandom,
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 31), $urandom_range(0, 25));
            n_chk++;
            if (wr_conflict !== exp_conf)
                $display("FAIL b2b_conflict c%0d: got %b want %b", i, wr_conflict, exp_conf);
            else n_pass++;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_chk++;
                if (rd_data[e.port*DW +: DW] !== e.data || rd_valid[e.port] !== 1'b1)
                    $display("FAIL b2b_read c%0d p%0d: got %h v=%b want %h v=1",
                             i, e.port, rd_data[e.port*DW +: DW], rd_valid[e.port], e.data);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_reg();
        test_collision();
        test_rdw();
        test_hold_range();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
